video_downscale_2x2: RTL and testbench

//  Downscales an AXI-Stream-style pixel stream by 2 in both dimensions: each 2x2 input block becomes one averaged pixel.

---
 rtl/video_ds_pkg.sv | 26 ++
 rtl/video_downscale_2x2_line_buffer.sv | 40 ++++
 rtl/video_downscale_2x2.sv | 149 ++++++++++++++
 tb/tb_video_downscale_2x2.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_ds_pkg.sv
// ----------------------------------------------------------------------------
// video_ds_pkg
//   Shared types and constants for the 2x2 video downscaler.
//   The pixel/sum typedefs describe the default 8-bit pixel build; the RTL
//   itself sizes its datapath from the D_WIDTH module parameter.
//   Build option: define DS2X2_ROUND_EN to round the 2x2 average half-up
//   instead of truncating it.
// ----------------------------------------------------------------------------
package video_ds_pkg;

  localparam int PIX_WIDTH  = 8;
  localparam int ROUND_BIAS = 2;

  typedef logic [PIX_WIDTH-1:0] pixel_t;     // one pixel
  typedef logic [PIX_WIDTH:0]   pair_sum_t;  // sum of two horizontal pixels
  typedef logic [PIX_WIDTH+1:0] quad_sum_t;  // sum of a 2x2 block

  // Row 0 / row 1 of the block, pixel 0 / pixel 1 of the horizontal pair.
  typedef enum logic [1:0] {
    R0_P0,
    R0_P1,
    R1_P0,
    R1_P1
  } ds_state_t;

endpackage

// File: rtl/video_downscale_2x2_line_buffer.sv
// ----------------------------------------------------------------------------
// line_buffer_sdp
//   Simple dual-port RAM holding the row-0 horizontal pair sums of one line.
//   One write port, one read port with a registered read (data appears the
//   clock after rd_en and holds until the next read).
//   Ports:
//     clk      clock
//     wr_en    write strobe
//     wr_addr  write address
//     wr_data  write data
//     rd_en    read strobe
//     rd_addr  read address
//     rd_data  registered read data
//   Writes happen only while processing row 0 and reads only in row 1, so the
//   two ports never touch the same entry in the same cycle.
// ----------------------------------------------------------------------------
module line_buffer_sdp #(
  parameter int WIDTH      = 9,
  parameter int DEPTH      = 960,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing a RAM would stop it mapping onto
  // block memory, and every entry is written before it is meaningfully read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/video_downscale_2x2.sv
// ----------------------------------------------------------------------------
// video_downscale_2x2
//   Halves a pixel stream in both dimensions: each 2x2 input block becomes one
//   averaged output pixel. Row-0 lines store horizontal pair sums in a line
//   buffer; row-1 lines add their own pair sums to the stored ones and emit.
//   Build option: DS2X2_ROUND_EN -> round half up, otherwise truncate.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     up_valid/up_ready/up_data     input pixel handshake and data
//     up_tlast, up_tuser            end of input line, start of frame
//     down_valid/down_ready         output handshake (valid is registered)
//     down_data                     averaged pixel
//     down_tlast, down_tuser        end of output line, first pixel of frame
// ----------------------------------------------------------------------------
module video_downscale_2x2
  import video_ds_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int MAX_WIDTH = 1920
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_tlast,
  output logic               down_tuser
);

  localparam int DEPTH      = MAX_WIDTH / 2;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(DEPTH - 1);

  ds_state_t               state;
  ds_state_t               cur;        // state this beat is processed in
  logic [ADDR_WIDTH-1:0]   col;
  logic                    col_ovf;    // line ran past the buffer depth
  logic                    sof_pend;
  logic [D_WIDTH:0]        pair_sum;   // holds the P0 pixel of the pair
  logic [D_WIDTH:0]        buf_rdata;
  logic [D_WIDTH+1:0]      sum4;
  logic [D_WIDTH+1:0]      sum4_adj;
  logic                    accept;
  logic                    wr_en;
  logic                    rd_en;
  logic                    emit;

  // Only the emitting beat can be blocked by a full output register.
  assign up_ready = (state == R1_P1) ? (~down_valid | down_ready) : 1'b1;
  assign accept   = up_valid & up_ready;

  // A start-of-frame beat is always handled as the first pixel of row 0.
  assign cur = up_tuser ? R0_P0 : state;

  assign wr_en = accept & (cur == R0_P1) & ~col_ovf;
  assign rd_en = accept & (cur == R1_P0);
  assign emit  = accept & (cur == R1_P1);

  assign sum4 = {1'b0, buf_rdata} + {1'b0, pair_sum} + (D_WIDTH+2)'(up_data);

`ifdef DS2X2_ROUND_EN
  assign sum4_adj = sum4 + (D_WIDTH+2)'(ROUND_BIAS);
`else
  assign sum4_adj = sum4;
`endif

  line_buffer_sdp #(
    .WIDTH      (D_WIDTH + 1),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (col),
    .wr_data (pair_sum + {1'b0, up_data}),
    .rd_en   (rd_en),
    .rd_addr (col),
    .rd_data (buf_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others; later assignments in the
  // block deliberately override earlier ones (e.g. tlast resetting col).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= R0_P0;
      col      <= '0;
      col_ovf  <= 1'b0;
      sof_pend <= 1'b0;
      pair_sum <= '0;
    end else if (accept) begin
      if (up_tuser) begin
        col      <= '0;
        col_ovf  <= 1'b0;
        sof_pend <= 1'b1;
      end
      unique case (cur)
        R0_P0, R1_P0: begin
          pair_sum <= {1'b0, up_data};
          if (up_tlast) begin
            // Odd-width line: the unpaired pixel is dropped.
            state   <= (cur == R0_P0) ? R1_P0 : R0_P0;
            col     <= '0;
            col_ovf <= 1'b0;
          end else begin
            state <= (cur == R0_P0) ? R0_P1 : R1_P1;
          end
        end
        R0_P1, R1_P1: begin
          if (cur == R1_P1) sof_pend <= 1'b0;
          if (up_tlast) begin
            state   <= (cur == R0_P1) ? R1_P0 : R0_P0;
            col     <= '0;
            col_ovf <= 1'b0;
          end else begin
            state <= (cur == R0_P1) ? R0_P0 : R1_P0;
            if (col == COL_MAX) col_ovf <= 1'b1;
            else                col     <= col + 1'b1;
          end
        end
      endcase
    end
  end

  // Output register: a consume and a new load in the same cycle leave
  // down_valid high with the new beat, so there is no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_tlast <= 1'b0;
      down_tuser <= 1'b0;
    end else begin
      if (down_ready) down_valid <= 1'b0;
      if (emit) begin
        down_valid <= 1'b1;
        down_data  <= sum4_adj[D_WIDTH+1:2];
        down_tlast <= up_tlast;
        down_tuser <= sof_pend;
      end
    end
  end

endmodule

// File: tb/tb_video_downscale_2x2.sv
// ----------------------------------------------------------------------------
// tb_video_downscale_2x2
//   Directed testbench for video_downscale_2x2 with hand-computed expected
//   pixels. Inputs change on the falling clock edge; accepted output beats
//   are captured into a queue and compared in order.
// ----------------------------------------------------------------------------
module tb_video_downscale_2x2;
  import video_ds_pkg::*;

  typedef struct {
    pixel_t d;
    logic   l;
    logic   u;
  } beat_t;

  logic   clk;
  logic   rst;
  logic   up_valid;
  logic   up_ready;
  pixel_t up_data;
  logic   up_tlast;
  logic   up_tuser;
  logic   down_valid;
  logic   down_ready;
  pixel_t down_data;
  logic   down_tlast;
  logic   down_tuser;

  int     checks   = 0;
  int     failures = 0;
  int     stalls   = 0;
  beat_t  outq[$];

`ifdef DS2X2_ROUND_EN
  localparam pixel_t EXP_SMALL = 8'd2;
`else
  localparam pixel_t EXP_SMALL = 8'd1;
`endif

  video_downscale_2x2 #(
    .D_WIDTH   (8),
    .MAX_WIDTH (1920)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_tlast   (up_tlast),
    .up_tuser   (up_tuser),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_tlast (down_tlast),
    .down_tuser (down_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture beats that will transfer on the coming rising edge.
  always @(negedge clk) begin
    #3;
    if (!rst && down_valid && down_ready)
      outq.push_back('{d: down_data, l: down_tlast, u: down_tuser});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input pixel_t d, input logic l, input logic u);
    logic rdy;
    int   n;
    up_valid = 1'b1;
    up_data  = d;
    up_tlast = l;
    up_tuser = u;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 100) begin
      #2 rdy = up_ready;
      @(negedge clk);
      n++;
    end
    stalls += n - 1;
    if (!rdy) check("send_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic idle();
    up_valid = 1'b0;
    up_tlast = 1'b0;
    up_tuser = 1'b0;
  endtask

  task automatic send_row4(input pixel_t a, input pixel_t b, input pixel_t c,
                           input pixel_t d, input logic sof);
    send(a, 1'b0, sof);
    send(b, 1'b0, 1'b0);
    send(c, 1'b0, 1'b0);
    send(d, 1'b1, 1'b0);
  endtask

  task automatic expect_out(input string tag, input pixel_t d, input logic l, input logic u);
    int    n;
    beat_t b;
    n = 0;
    while (outq.size() == 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (outq.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      b = outq.pop_front();
      check({tag, "_data"},  32'(b.d), 32'(d));
      check({tag, "_tlast"}, 32'(b.l), 32'(l));
      check({tag, "_tuser"}, 32'(b.u), 32'(u));
    end
  endtask

  task automatic expect_drained(input string tag);
    repeat (4) @(negedge clk);
    check(tag, 32'(outq.size()), 32'd0);
  endtask

  initial begin
    pixel_t exp4 [8] = '{8'd10, 8'd18, 8'd26, 8'd34, 8'd42, 8'd50, 8'd58, 8'd66};

    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    up_tlast   = 1'b0;
    up_tuser   = 1'b0;
    down_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_down_data",  32'(down_data),  32'd0);
    check("rst_down_tlast", 32'(down_tlast), 32'd0);
    check("rst_down_tuser", 32'(down_tuser), 32'd0);
    check("rst_up_ready",   32'(up_ready),   32'd1);

    // 1. Basic 4x2 frame
    send_row4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send_row4(8'd50, 8'd60, 8'd70, 8'd80, 1'b0);
    idle();
    expect_out("t1_o0", 8'd35, 1'b0, 1'b1);
    expect_out("t1_o1", 8'd55, 1'b1, 1'b0);
    expect_drained("t1_extra");

    // 2. Rounding and full-scale blocks, one 2x2 frame each
    send(8'd1, 1'b0, 1'b1); send(8'd2, 1'b1, 1'b0);
    send(8'd2, 1'b0, 1'b0); send(8'd2, 1'b1, 1'b0);
    send(8'd255, 1'b0, 1'b1); send(8'd255, 1'b1, 1'b0);
    send(8'd255, 1'b0, 1'b0); send(8'd255, 1'b1, 1'b0);
    idle();
    expect_out("t2_small", EXP_SMALL, 1'b1, 1'b1);
    expect_out("t2_full",  8'd255,    1'b1, 1'b1);
    expect_drained("t2_extra");

    // 3. Backpressure on the 4x2 frame
    down_ready = 1'b0;
    send_row4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send(8'd50, 1'b0, 1'b0);
    send(8'd60, 1'b0, 1'b0);
    send(8'd70, 1'b0, 1'b0);
    up_valid = 1'b1; up_data = 8'd80; up_tlast = 1'b1; up_tuser = 1'b0;
    repeat (3) begin
      #2;
      check("t3_up_ready_low", 32'(up_ready),   32'd0);
      check("t3_hold_valid",   32'(down_valid), 32'd1);
      check("t3_hold_data",    32'(down_data),  32'd35);
      @(negedge clk);
    end
    down_ready = 1'b1;
    send(8'd80, 1'b1, 1'b0);
    idle();
    expect_out("t3_o0", 8'd35, 1'b0, 1'b1);
    expect_out("t3_o1", 8'd55, 1'b1, 1'b0);
    expect_drained("t3_extra");

    // 4. Back-to-back 8x4 ramp frame, pixel = 16*row + 4*col
    stalls = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        send(pixel_t'(16 * r + 4 * c), c == 7, r == 0 && c == 0);
    idle();
    check("t4_no_stall", 32'(stalls), 32'd0);
    for (int i = 0; i < 8; i++)
      expect_out($sformatf("t4_o%0d", i), exp4[i], i == 3 || i == 7, i == 0);
    expect_drained("t4_extra");

    // 5. Start of frame in the middle of row 1
    send_row4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send(8'd50, 1'b0, 1'b0);
    send_row4(8'd100, 8'd102, 8'd104, 8'd106, 1'b1);
    send_row4(8'd108, 8'd110, 8'd112, 8'd114, 1'b0);
    idle();
    expect_out("t5_o0", 8'd105, 1'b0, 1'b1);
    expect_out("t5_o1", 8'd109, 1'b1, 1'b0);
    expect_drained("t5_extra");

    // 6. Asynchronous reset with a beat waiting in the output register
    down_ready = 1'b0;
    send_row4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    send(8'd50, 1'b0, 1'b0);
    send(8'd60, 1'b0, 1'b0);
    idle();
    check("t6_pre_valid", 32'(down_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid",    32'(down_valid), 32'd0);
    check("t6_rst_data",     32'(down_data),  32'd0);
    check("t6_rst_up_ready", 32'(up_ready),   32'd1);
    @(negedge clk);
    rst        = 1'b0;
    down_ready = 1'b1;
    send_row4(8'd4,  8'd8,  8'd12, 8'd16, 1'b1);
    send_row4(8'd20, 8'd24, 8'd28, 8'd32, 1'b0);
    idle();
    expect_out("t6_o0", 8'd14, 1'b0, 1'b1);
    expect_out("t6_o1", 8'd22, 1'b1, 1'b0);
    expect_drained("t6_extra");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
